// File: rtl/set_region_counter.sv
// Two-circle lattice-point counter: scans the grid one point per cycle through a
// 2-stage classify/accumulate pipeline and reports the count of the selected region.
module set_region_counter #(
  parameter int COORD_W = 4,
  parameter int GRID_LO = 1,
  parameter int GRID_HI = 8,
  parameter int CNT_W   = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [4*COORD_W-1:0]   central,
  input  logic [2*COORD_W-1:0]   radius,
  input  logic [1:0]             mode,
  output logic                   busy,
  output logic                   valid,
  output logic [CNT_W-1:0]       candidate
);

  localparam int SQ_W  = 2*COORD_W;
  localparam int SUM_W = SQ_W + 1;
  localparam logic [COORD_W-1:0] LO = COORD_W'(GRID_LO);
  localparam logic [COORD_W-1:0] HI = COORD_W'(GRID_HI);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    logic signed [COORD_W:0] d;
    logic signed [COORD_W:0] n;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    n = -d;
    abs_diff = d[COORD_W] ? n[COORD_W-1:0] : d[COORD_W-1:0];
  endfunction

  // Boundary points count as inside; the sum carries one extra bit so it never wraps.
  function automatic logic in_circle(input logic [COORD_W-1:0] dx,
                                     input logic [COORD_W-1:0] dy,
                                     input logic [COORD_W-1:0] r);
    logic [SQ_W-1:0]  dxe, dye, re;
    logic [SQ_W-1:0]  sqx, sqy, sqr;
    logic [SUM_W-1:0] sum;
    dxe = {{COORD_W{1'b0}}, dx};
    dye = {{COORD_W{1'b0}}, dy};
    re  = {{COORD_W{1'b0}}, r};
    sqx = dxe * dxe;
    sqy = dye * dye;
    sqr = re * re;
    sum = {1'b0, sqx} + {1'b0, sqy};
    in_circle = (sum <= {1'b0, sqr});
  endfunction

  function automatic logic region_hit(input logic [1:0] m, input logic a, input logic b);
    case (m)
      2'b00:   region_hit = a;
      2'b01:   region_hit = a & b;
      2'b10:   region_hit = a ^ b;
      default: region_hit = a | b;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  state_t               state_q, state_d;
  logic [COORD_W-1:0]   x_q, y_q;
  logic                 vld_p1;
  logic [CNT_W-1:0]     acc_q;
  logic [CNT_W-1:0]     candidate_q;

  logic [4*COORD_W-1:0] cen_q;
  logic [2*COORD_W-1:0] rad_q;
  logic [1:0]           mode_q;

  logic [COORD_W-1:0]   dxa_p1, dya_p1, dxb_p1, dyb_p1;
  logic                 rej_a_p1, rej_b_p1;

  logic                 start, cap, last_pt;
  logic [COORD_W-1:0]   ax, ay, bx, by, ra, rb;
  logic [COORD_W-1:0]   dxa, dya, dxb, dyb;
  logic                 in_a, in_b, hit;

  assign ax = cen_q[4*COORD_W-1:3*COORD_W];
  assign ay = cen_q[3*COORD_W-1:2*COORD_W];
  assign bx = cen_q[2*COORD_W-1:COORD_W];
  assign by = cen_q[COORD_W-1:0];
  assign ra = rad_q[2*COORD_W-1:COORD_W];
  assign rb = rad_q[COORD_W-1:0];

  assign last_pt = (x_q == HI) && (y_q == HI);

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    cap     = 1'b0;
    case (state_q)
      IDLE:  if (en) start = 1'b1;
      SCAN:  if (last_pt) state_d = DRAIN;
      DRAIN: if (!vld_p1) begin
               state_d = DONE;
               cap     = 1'b1;
             end
      DONE:  if (en) start = 1'b1;
             else    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (start) state_d = SCAN;
  end

  assign busy      = (state_q == SCAN) || (state_q == DRAIN);
  assign valid     = (state_q == DONE);
  assign candidate = candidate_q;

  // Stage 1 (combinational into _p1): per-circle distances and early reject.
  assign dxa = abs_diff(x_q, ax);
  assign dya = abs_diff(y_q, ay);
  assign dxb = abs_diff(x_q, bx);
  assign dyb = abs_diff(y_q, by);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= LO;
      y_q         <= LO;
      vld_p1      <= 1'b0;
      acc_q       <= '0;
      candidate_q <= '0;
    end else begin
      state_q <= state_d;
      vld_p1  <= (state_q == SCAN);
      if (start) begin
        x_q <= LO;
        y_q <= LO;
      end else if (state_q == SCAN) begin
        if (x_q == HI) begin
          x_q <= LO;
          y_q <= y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
      if (start)              acc_q <= '0;
      else if (vld_p1 && hit) acc_q <= sat_inc(acc_q);
      if (cap) candidate_q <= acc_q;
    end
  end

  // Job parameters are only captured at job start, so mid-job input changes are invisible.
  always_ff @(posedge clk) begin
    if (start) begin
      cen_q  <= central;
      rad_q  <= radius;
      mode_q <= mode;
    end
    if (state_q == SCAN) begin
      dxa_p1   <= dxa;
      dya_p1   <= dya;
      dxb_p1   <= dxb;
      dyb_p1   <= dyb;
      rej_a_p1 <= (dxa > ra) || (dya > ra);
      rej_b_p1 <= (dxb > rb) || (dyb > rb);
    end
  end

  // Stage 2: squared-distance compare, region select, accumulate.
  assign in_a = !rej_a_p1 && in_circle(dxa_p1, dya_p1, ra);
  assign in_b = !rej_b_p1 && in_circle(dxb_p1, dyb_p1, rb);
  assign hit  = region_hit(mode_q, in_a, in_b);

endmodule

// File: tb/tb_set_region_counter.sv
// Directed bench for set_region_counter: expected counts queued at job start and
// checked against candidate when valid strobes.
module tb_set_region_counter;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [15:0] central;
  logic [7:0]  radius;
  logic [1:0]  mode;
  logic        busy, valid;
  logic [6:0]  candidate;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int valid_cnt = 0;
  int e0     = 0;
  int vc     = 0;
  int exp_q[$];

  set_region_counter #(.COORD_W(4), .GRID_LO(1), .GRID_HI(8), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .en(en), .central(central), .radius(radius),
    .mode(mode), .busy(busy), .valid(valid), .candidate(candidate)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (valid) valid_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] c, input logic [7:0] r,
                           input logic [1:0] m, input int expv);
    central = c;
    radius  = r;
    mode    = m;
    en      = 1'b1;
    tick();
    e0 = cyc;
    en = 1'b0;
    if (expv >= 0) exp_q.push_back(expv);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    int expv;
    n = 0;
    while (!valid && n < 200) begin
      tick();
      n++;
    end
    chk({tag, "_seen"}, valid, 1);
    if (valid) begin
      chk({tag, "_lat"}, cyc - e0, 66);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_sbq"}, exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        expv = exp_q.pop_front();
        chk({tag, "_cnt"}, candidate, expv);
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; central = '0; radius = '0; mode = '0;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_cand", candidate, 0);
    rst = 1'b0;
    tick();

    // Single circle A=(4,4) r=2
    start_job(16'h4400, 8'h20, 2'b00, 13);
    chk("t1_busy_run", busy, 1);
    wait_valid("t1");
    tick();
    chk("t1_pulse", valid, 0);
    chk("t1_hold", candidate, 13);

    // Two circles A=(4,4) r2, B=(6,4) r2
    start_job(16'h4464, 8'h22, 2'b01, 5);
    wait_valid("t2_and");
    tick();
    start_job(16'h4464, 8'h22, 2'b10, 16);
    wait_valid("t2_xor");
    tick();
    start_job(16'h4464, 8'h22, 2'b11, 21);
    wait_valid("t2_or");
    tick();

    // Clipping and zero radius
    start_job(16'h1100, 8'h20, 2'b00, 6);
    wait_valid("t3_clip");
    tick();
    start_job(16'h8800, 8'h00, 2'b00, 1);
    wait_valid("t3_r0in");
    tick();
    start_job(16'h0000, 8'h00, 2'b00, 0);
    wait_valid("t3_r0out");
    tick();

    // en pulses while busy are ignored
    start_job(16'h4400, 8'h20, 2'b00, 13);
    vc = valid_cnt;
    while (cyc < e0 + 9) tick();
    en = 1'b1; central = 16'h1100; radius = 8'h77; mode = 2'b11;
    tick();
    en = 1'b0;
    while (cyc < e0 + 39) tick();
    en = 1'b1;
    tick();
    en = 1'b0;
    wait_valid("t4");
    repeat (20) tick();
    chk("t4_one_valid", valid_cnt - vc, 1);

    // Asynchronous reset mid-job aborts it
    start_job(16'h4400, 8'h20, 2'b00, -1);
    while (cyc < e0 + 30) tick();
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_valid", valid, 0);
    chk("t5_cand", candidate, 0);
    tick();
    rst = 1'b0;
    vc = valid_cnt;
    repeat (80) tick();
    chk("t5_abort", valid_cnt - vc, 0);
    start_job(16'h4400, 8'h20, 2'b00, 13);
    wait_valid("t5_fresh");
    tick();

    // Back-to-back jobs: en accepted in the valid cycle
    start_job(16'h4400, 8'h20, 2'b00, 13);
    wait_valid("t6a");
    start_job(16'h4464, 8'h22, 2'b01, 5);
    chk("t6_busy", busy, 1);
    while (cyc < e0 + 30) tick();
    chk("t6_held", candidate, 13);
    wait_valid("t6b");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
